button_input: RTL and testbench



---
 rtl/button_pkg.sv | 31 +++
 rtl/button_channel.sv | 180 ++++++++++++++++++
 rtl/button_input.sv | 59 +++++
 tb/tb_button_input.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared types and default timing constants for the push-button
//               conditioning block (12 MHz system clock).
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

  // System clock frequency the default timings are derived from.
  localparam int CLK_HZ        = 12_000_000;

  // Default timings: 10 ms debounce, 1 s long press, 200 ms auto-repeat.
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int LONG_1S       = CLK_HZ;
  localparam int REPEAT_200MS  = CLK_HZ / 5;

  // Per-channel press state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  // Width of a counter that must hold values 0 .. n-1 (never narrower than 1).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One push-button channel: two-flop synchroniser, debounce
//               counter, press/release/long-press state machine and, when
//               BUTTON_AUTOREPEAT_EN is defined, auto-repeat of the press
//               event while the button is held.
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
  parameter int LONG_PRESS_CYCLES = LONG_1S,
`ifdef BUTTON_AUTOREPEAT_EN
  parameter int REPEAT_CYCLES     = REPEAT_200MS,
`endif
  parameter bit ACTIVE_LOW        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int LW = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [DW-1:0] r_dcnt;
  logic [LW-1:0] r_lcnt;
  btn_state_t    r_state;
  btn_state_t    w_state_nxt;
  logic          r_press;
  logic          r_release;
  logic          r_long;
  logic          w_norm;
  logic          w_accept;
  logic          w_rise;
  logic          w_fall;
  logic          w_repeat;
  logic          w_press_nxt;
  logic          w_release_nxt;
  logic          w_long_nxt;

  // Synchroniser resets to the idle pad level so no spurious press follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Normalised level (1 = pressed) and the debounced edge that is about to be taken.
  assign w_norm   = r_sync2 ^ ACTIVE_LOW;
  assign w_accept = (w_norm != r_level) && (r_dcnt == DB_LAST);
  assign w_rise   = w_accept &  w_norm;
  assign w_fall   = w_accept & ~w_norm;

  // Debounce: a new level is accepted only after it has been stable for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt  <= '0;
      r_level <= 1'b0;
    end else if (w_norm == r_level) begin
      r_dcnt  <= '0;
    end else if (r_dcnt == DB_LAST) begin
      r_level <= w_norm;
      r_dcnt  <= '0;
    end else begin
      r_dcnt  <= r_dcnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a release always wins over a long press reached in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
        end else if (r_lcnt == LP_LAST) begin
          w_state_nxt = HELD;
        end
      end
      HELD: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Long-press counter: cleared while idle, runs in PRESSED, frozen at its limit in HELD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lcnt <= '0;
    end else if (r_state == IDLE) begin
      r_lcnt <= '0;
    end else if ((r_state == PRESSED) && !w_fall && (r_lcnt != LP_LAST)) begin
      r_lcnt <= r_lcnt + 1'b1;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rcnt;

  assign w_repeat = (r_state == HELD) && !w_fall && (r_rcnt == RP_LAST);

  // Repeat counter: zero outside HELD (so it starts fresh on entry), restarts after each repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt <= '0;
    end else if ((r_state != HELD) || w_fall || (r_rcnt == RP_LAST)) begin
      r_rcnt <= '0;
    end else begin
      r_rcnt <= r_rcnt + 1'b1;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  // Output decode: next value of each event pulse.
  always_comb begin
    w_press_nxt   = ((r_state == IDLE) && w_rise) || w_repeat;
    w_release_nxt = (r_state != IDLE) && w_fall;
    w_long_nxt    = (r_state == PRESSED) && !w_fall && (r_lcnt == LP_LAST);
  end

  // Event pulses are registered so they line up with the debounced level update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

endmodule : button_channel
`default_nettype wire

// File: rtl/button_input.sv
`default_nettype none
// ============================================================================
// Module      : button_input
// Description : Conditions NUM_BTN raw push-button pads into a debounced
//               level plus one-cycle press, release and long-press events.
//               Optional macro BUTTON_AUTOREPEAT_EN repeats the press event
//               every REPEAT_CYCLES while a button is held past long press.
// Revision    : 1.0 - initial release
// ============================================================================
module button_input
  import button_pkg::*;
#(
  parameter int                 NUM_BTN           = 3,
  parameter logic [NUM_BTN-1:0] BTN_ACTIVE_LOW    = '0,
  parameter int                 DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
  parameter int                 LONG_PRESS_CYCLES = LONG_1S,
  parameter int                 REPEAT_CYCLES     = REPEAT_200MS
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_BTN-1:0] BTN_IN,
  output logic [NUM_BTN-1:0] BTN_LEVEL,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic [NUM_BTN-1:0] BTN_RELEASE,
  output logic [NUM_BTN-1:0] BTN_LONG
);

  // Reject timing configurations the channel counters cannot honour.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_input: DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("button_input: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("button_input: REPEAT_CYCLES must be at least 1");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
`ifdef BUTTON_AUTOREPEAT_EN
      .REPEAT_CYCLES     (REPEAT_CYCLES),
`endif
      .ACTIVE_LOW        (BTN_ACTIVE_LOW[i])
    ) u_chan (
      .clk       (CLK),
      .rst_n     (RST_N),
      .i_btn     (BTN_IN[i]),
      .o_level   (BTN_LEVEL[i]),
      .o_press   (BTN_PRESS[i]),
      .o_release (BTN_RELEASE[i]),
      .o_long    (BTN_LONG[i])
    );
  end

endmodule : button_input
`default_nettype wire

// File: tb/tb_button_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_input
// Description : Self-checking bench for button_input: directed timing
//               sequences, a table of hold lengths with expected event
//               counts, and random pad activity compared every cycle with a
//               sliding-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_input;

  localparam int         NB   = 3;
  localparam logic [2:0] MASK = 3'b001;
  localparam int         D    = 4;
  localparam int         L    = 20;
  localparam int         R    = 8;

  logic          CLK    = 1'b0;
  logic          RST_N  = 1'b0;
  logic [NB-1:0] BTN_IN = MASK;
  logic [NB-1:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG;

  button_input #(
    .NUM_BTN           (NB),
    .BTN_ACTIVE_LOW    (MASK),
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .REPEAT_CYCLES     (R)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .BTN_IN      (BTN_IN),
    .BTN_LEVEL   (BTN_LEVEL),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE),
    .BTN_LONG    (BTN_LONG)
  );

  always #5 CLK = ~CLK;

  int chk = 0;
  int err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model -----------------------------------
  // Level flips once the last D normalised samples all disagree with it;
  // events are derived from the time elapsed since the press.
  logic [NB-1:0] m_s1, m_s2, m_lvl;
  logic [D-1:0]  m_nh [NB];
  int            m_t  [NB];
  logic [NB-1:0] e_press, e_rel, e_long;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_s1 = MASK; m_s2 = MASK; m_lvl = '0;
      e_press = '0; e_rel = '0; e_long = '0;
      for (int i = 0; i < NB; i++) begin
        m_nh[i] = '0;
        m_t[i]  = -1;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        logic n;
        logic flip;
        n = m_s2[i] ^ MASK[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = BTN_IN[i];
        m_nh[i] = {m_nh[i][D-2:0], n};
        flip = (m_nh[i] == {D{~m_lvl[i]}});
        e_press[i] = 1'b0; e_rel[i] = 1'b0; e_long[i] = 1'b0;
        if (flip && !m_lvl[i]) begin
          m_lvl[i] = 1'b1; e_press[i] = 1'b1; m_t[i] = 0;
        end else if (flip) begin
          m_lvl[i] = 1'b0; e_rel[i] = 1'b1; m_t[i] = -1;
        end else if (m_lvl[i]) begin
          m_t[i]++;
          if (m_t[i] == L) e_long[i] = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
          if (m_t[i] > L && ((m_t[i] - L) % R) == 0) e_press[i] = 1'b1;
`endif
        end
      end
    end
  end

  // ---------------- per-cycle comparison and event counters ----------
  bit chk_en = 1'b0;
  int n_press [NB];
  int n_rel   [NB];
  int n_long  [NB];

  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      check("model_level",   BTN_LEVEL,   m_lvl);
      check("model_press",   BTN_PRESS,   e_press);
      check("model_release", BTN_RELEASE, e_rel);
      check("model_long",    BTN_LONG,    e_long);
    end
    for (int i = 0; i < NB; i++) begin
      if (BTN_PRESS[i] === 1'b1)   n_press[i]++;
      if (BTN_RELEASE[i] === 1'b1) n_rel[i]++;
      if (BTN_LONG[i] === 1'b1)    n_long[i]++;
    end
  end

  // ---------------- helpers ------------------------------------------
  task automatic set_btn(input int ch, input bit pressed);
    BTN_IN[ch] = pressed ^ MASK[ch];
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NB; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
    end
  endtask

  // Edges until an event (0 press, 1 release, 2 long) on ch; -1 if the bound expires.
  task automatic edges_until(input int ch, input int kind, input int limit, output int j);
    j = 0;
    while (j < limit) begin
      @(posedge CLK); #1; j++;
      if (kind == 0 && BTN_PRESS[ch] === 1'b1)   return;
      if (kind == 1 && BTN_RELEASE[ch] === 1'b1) return;
      if (kind == 2 && BTN_LONG[ch] === 1'b1)    return;
    end
    j = -1;
  endtask

  typedef struct {
    int ch;
    int hold;
    int e_press;
    int e_long;
    int e_rel;
  } vec_t;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  initial begin
    vec_t tbl [6];
    int   j;
    bit   bounce [12];
    int   rem [NB];

    tbl[0] = '{0, 10, 1, 0, 1};
    tbl[1] = '{1,  3, 0, 0, 0};
    tbl[2] = '{1,  4, 1, 0, 1};
    tbl[3] = '{2, 21, 1, 1, 1};
    tbl[4] = '{0, 50, (AR != 0) ? 4 : 1, 1, 1};
    tbl[5] = '{2, 40, (AR != 0) ? 3 : 1, 1, 1};
    bounce = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};

    // Reset with ch0 (active-low) idling high.
    clear_counts();
    tick(3);
    check("reset_level",   BTN_LEVEL,   0);
    check("reset_press",   BTN_PRESS,   0);
    check("reset_release", BTN_RELEASE, 0);
    check("reset_long",    BTN_LONG,    0);
    chk_en = 1'b1;
    RST_N  = 1'b1;

    // Idle active-low input yields no events.
    tick(20);
    check("idle_no_press", n_press[0] + n_rel[0] + n_long[0], 0);
    check("idle_level",    BTN_LEVEL, 0);

    // Clean press on ch0: press 6 samples after the drive (edge k+5).
    clear_counts();
    set_btn(0, 1'b1);
    edges_until(0, 0, 20, j);
    check("clean_press_latency", j, D + 2);
    repeat (5) @(negedge CLK);
    set_btn(0, 1'b0);
    edges_until(0, 1, 20, j);
    check("clean_release_latency", j, D + 2);
    tick(10);
    check("clean_press_count", n_press[0], 1);
    check("clean_long_count",  n_long[0],  0);

    // Bounce on ch1 then a stable press.
    clear_counts();
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      set_btn(1, bounce[k]);
    end
    @(negedge CLK);
    set_btn(1, 1'b1);
    edges_until(1, 0, 20, j);
    check("bounce_press_latency", j, D + 2);
    check("bounce_press_count",   n_press[1], 1);
    @(negedge CLK);
    set_btn(1, 1'b0);
    tick(15);

    // Long press on ch2 held 40 cycles.
    clear_counts();
    set_btn(2, 1'b1);
    edges_until(2, 0, 20, j);
    check("long_press_latency", j, D + 2);
    edges_until(2, 2, 40, j);
    check("long_after_press", j, L);
    repeat (15) @(negedge CLK);
    set_btn(2, 1'b0);
    edges_until(2, 1, 20, j);
    check("long_release_latency", j, D + 2);
    tick(10);
    check("long_count",    n_long[2],  1);
    check("long_rel_count", n_rel[2],  1);
    check("long_press_count", n_press[2], 1 + 2 * AR);

    // Reset asserted while HELD, button still held afterwards.
    clear_counts();
    set_btn(2, 1'b1);
    edges_until(2, 2, 40, j);
    check("rst_reach_long", j, D + 2 + L);
    tick(3);
    RST_N = 1'b0;
    #1;
    check("rst_async_level", BTN_LEVEL,   0);
    check("rst_async_press", BTN_PRESS,   0);
    check("rst_async_long",  BTN_LONG,    0);
    tick(3);
    RST_N = 1'b1;
    edges_until(2, 0, 20, j);
    check("rst_fresh_press", j, D + 2);
    check("rst_no_release",  n_rel[2], 0);
    @(negedge CLK);
    set_btn(2, 1'b0);
    tick(15);

    // Table of hold lengths with expected event counts.
    foreach (tbl[t]) begin
      clear_counts();
      @(negedge CLK);
      set_btn(tbl[t].ch, 1'b1);
      repeat (tbl[t].hold) @(negedge CLK);
      set_btn(tbl[t].ch, 1'b0);
      tick(30);
      check($sformatf("tbl%0d_press", t),   n_press[tbl[t].ch], tbl[t].e_press);
      check($sformatf("tbl%0d_long", t),    n_long[tbl[t].ch],  tbl[t].e_long);
      check($sformatf("tbl%0d_release", t), n_rel[tbl[t].ch],   tbl[t].e_rel);
    end

    // Random pad activity on all channels, one mid-run reset.
    for (int i = 0; i < NB; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (c == 1500) RST_N = 1'b0;
      if (c == 1503) RST_N = 1'b1;
      for (int i = 0; i < NB; i++) begin
        if (rem[i] == 0) begin
          BTN_IN[i] = 1'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(1, 45));
        end else begin
          rem[i]--;
        end
      end
    end
    @(negedge CLK);
    for (int i = 0; i < NB; i++) set_btn(i, 1'b0);
    tick(20);
    check("final_level", BTN_LEVEL, 0);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule : tb_button_input
`default_nettype wire
